// File: rtl/ped_phase_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ped_phase_scheduler_pkg
// Purpose  : Shared types and helpers for the pedestrian phase scheduler.
//            Provides the phase encoding, the seconds-counter width and the
//            RED -> GREEN -> FLASH -> RED successor function.
// Revision : 1.0  initial release
// ============================================================================
package ped_phase_scheduler_pkg;

    localparam int SEC_W = 5;

    // Encoding is visible on the phase output port, so values are fixed.
    typedef enum logic [1:0] {
        PH_RED   = 2'b00,
        PH_GREEN = 2'b01,
        PH_FLASH = 2'b10
    } phase_t;

    function automatic phase_t next_phase(input phase_t ph);
        phase_t nx;
        case (ph)
            PH_RED:   nx = PH_GREEN;
            PH_GREEN: nx = PH_FLASH;
            default:  nx = PH_RED;
        endcase
        return nx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ped_phase_scheduler_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : ped_phase_scheduler_tick_gen
// Purpose  : Prescaler producing one countdown tick every TICK_DIV clocks.
//            Counts 0..TICK_DIV-1 and wraps; o_tick is high in the cycle the
//            count sits at TICK_DIV-1 (and the prescaler is not held).
// Ports    : clk      system clock
//            rst      asynchronous active-high reset (count -> 0)
//            i_hold   freeze the count and suppress the tick
//            i_clear  force the count back to 0 (wins over hold)
//            o_tick   one-clk tick pulse
// Revision : 1.0  initial release
// ============================================================================
module ped_phase_scheduler_tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_hold,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == c_LAST);
    assign o_tick    = w_at_last && !i_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (!i_hold) begin
            r_cnt <= w_at_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ped_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ped_phase_scheduler
// Purpose  : Pedestrian-crossing phase sequencer. Runs RED -> GREEN -> FLASH
//            with a per-phase 1 Hz countdown, pedestrian-request shortening of
//            RED, pause, and a manual next-phase strobe.
// Ports    : clk, rst (async, active high)
//            pause         freeze prescaler and countdown (level)
//            change_state  rising edge forces the next phase
//            ped_req       asynchronous button, synchronised internally
//            second        remaining seconds of the current phase (N..1)
//            phase         00 RED, 01 GREEN, 10 FLASH
//            pattern       1 = walk figure, 0 = stop figure
//            quick         1 only in FLASH
//            tick          one-clk pulse per countdown tick
//            req_pending   pedestrian request latched, not yet served
// Revision : 1.0  initial release
// ============================================================================
module ped_phase_scheduler
    import ped_phase_scheduler_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned RED_SEC   = 15,
    parameter int unsigned GREEN_SEC = 10,
    parameter int unsigned FLASH_SEC = 5,
    parameter int unsigned MIN_RED_S = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             change_state,
    input  logic             ped_req,
    output logic [SEC_W-1:0] second,
    output logic [1:0]       phase,
    output logic             pattern,
    output logic             quick,
    output logic             tick,
    output logic             req_pending
);

    localparam logic [SEC_W-1:0] c_RED_LEN   = SEC_W'(RED_SEC);
    localparam logic [SEC_W-1:0] c_GREEN_LEN = SEC_W'(GREEN_SEC);
    localparam logic [SEC_W-1:0] c_FLASH_LEN = SEC_W'(FLASH_SEC);
    localparam logic [SEC_W-1:0] c_MIN_RED   = SEC_W'(MIN_RED_S);

    function automatic logic [SEC_W-1:0] phase_len(input phase_t ph);
        logic [SEC_W-1:0] len;
        case (ph)
            PH_GREEN: len = c_GREEN_LEN;
            PH_FLASH: len = c_FLASH_LEN;
            default:  len = c_RED_LEN;
        endcase
        return len;
    endfunction

    phase_t           r_phase;
    phase_t           w_phase_nx;
    logic [SEC_W-1:0] r_second;
    logic [SEC_W-1:0] w_second_nx;
    logic             r_req_pending;
    logic             w_req_nx;

    logic             r_cs_d;
    logic             r_ped_s1;
    logic             r_ped_s2;
    logic             r_ped_d;

    logic             w_cs_edge;
    logic             w_ped_edge;
    logic             w_tick;
    logic             w_is_red;
    logic             w_advance;

    assign w_cs_edge  = change_state && !r_cs_d;
    assign w_ped_edge = r_ped_s2 && !r_ped_d;
    assign w_is_red   = (r_phase == PH_RED);
    // A manual strobe outranks any tick; a tick at the last second rolls over.
    assign w_advance  = w_cs_edge || (w_tick && (r_second == SEC_W'(1)));

    ped_phase_scheduler_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (pause),
        .i_clear (w_advance),
        .o_tick  (w_tick)
    );

    // Edge-detect and button synchroniser registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_d   <= 1'b0;
            r_ped_s1 <= 1'b0;
            r_ped_s2 <= 1'b0;
            r_ped_d  <= 1'b0;
        end else begin
            r_cs_d   <= change_state;
            r_ped_s1 <= ped_req;
            r_ped_s2 <= r_ped_s1;
            r_ped_d  <= r_ped_s2;
        end
    end

    // Phase / countdown / request state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase       <= PH_RED;
            r_second      <= c_RED_LEN;
            r_req_pending <= 1'b0;
        end else begin
            r_phase       <= w_phase_nx;
            r_second      <= w_second_nx;
            r_req_pending <= w_req_nx;
        end
    end

    always_comb begin
        w_phase_nx  = r_phase;
        w_second_nx = r_second;
        w_req_nx    = r_req_pending;

        if (w_advance) begin
            w_phase_nx  = next_phase(r_phase);
            w_second_nx = phase_len(next_phase(r_phase));
        end else if (w_tick) begin
            // A pending request only shortens RED when it actually saves time.
            if (w_is_red && r_req_pending && (r_second > c_MIN_RED)) begin
                w_second_nx = c_MIN_RED;
            end else begin
                w_second_nx = r_second - SEC_W'(1);
            end
        end

        // Leaving RED always drops the request; a fresh press outranks the
        // tick that consumes the previous one.
        if (w_advance) begin
            w_req_nx = 1'b0;
        end else if (w_ped_edge && w_is_red) begin
            w_req_nx = 1'b1;
        end else if (w_tick && w_is_red) begin
            w_req_nx = 1'b0;
        end
    end

    assign second      = r_second;
    assign phase       = r_phase;
    assign pattern     = (r_phase != PH_RED);
    assign quick       = (r_phase == PH_FLASH);
    assign tick        = w_tick;
    assign req_pending = r_req_pending;

endmodule
`default_nettype wire

// File: tb/tb_ped_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ped_phase_scheduler
// Purpose  : Scoreboard bench for ped_phase_scheduler. A driver applies
//            directed and random stimulus on the falling edge, advances a
//            behavioural model of the crossing and queues the state expected
//            after the next rising edge; a monitor compares after each edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_ped_phase_scheduler;

    localparam int TD = 4;
    localparam int RS = 6;
    localparam int GS = 4;
    localparam int FS = 3;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pause = 1'b0;
    logic       change_state = 1'b0;
    logic       ped_req = 1'b0;
    logic [4:0] second;
    logic [1:0] phase;
    logic       pattern;
    logic       quick;
    logic       tick;
    logic       req_pending;

    always #5 clk = ~clk;

    ped_phase_scheduler #(
        .TICK_DIV  (TD),
        .RED_SEC   (RS),
        .GREEN_SEC (GS),
        .FLASH_SEC (FS),
        .MIN_RED_S (MR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pause        (pause),
        .change_state (change_state),
        .ped_req      (ped_req),
        .second       (second),
        .phase        (phase),
        .pattern      (pattern),
        .quick        (quick),
        .tick         (tick),
        .req_pending  (req_pending)
    );

    typedef struct {
        int ph;
        int sec;
        bit pend;
        bit tk;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // ---------------- behavioural model ----------------
    int len_of[3] = '{RS, GS, FS};
    int m_ph, m_sec, m_cnt;
    bit m_pend, m_cs_prev;
    bit m_btn[3];   // button samples: [0] newest, request visible at [1]&!![2]

    task automatic model_reset();
        m_ph = 0; m_sec = RS; m_cnt = 0; m_pend = 0; m_cs_prev = 0;
        for (int i = 0; i < 3; i++) m_btn[i] = 0;
    endtask

    function automatic void check(input string nm, input exp_t e);
        int a_ph, a_sec;
        a_ph  = int'(phase);
        a_sec = int'(second);
        n_vec++;
        if (a_ph != e.ph || a_sec != e.sec || req_pending != e.pend || tick != e.tk ||
            pattern != (e.ph != 0) || quick != (e.ph == 2)) begin
            n_mis++;
            $display("FAIL %s t=%0t: got ph=%0d sec=%0d pend=%0b tick=%0b pat=%0b quick=%0b, want ph=%0d sec=%0d pend=%0b tick=%0b pat=%0b quick=%0b",
                     nm, $time, a_ph, a_sec, req_pending, tick, pattern, quick,
                     e.ph, e.sec, e.pend, e.tk, (e.ph != 0), (e.ph == 2));
        end
    endfunction

    // One clock of stimulus: drive inputs, predict the post-edge state.
    task automatic step(input bit p, input bit c, input bit r);
        bit   tk, ce, pe, red, leave;
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        pause = p; change_state = c; ped_req = r;

        tk    = (m_cnt == TD - 1) && !p;
        ce    = c && !m_cs_prev;
        pe    = m_btn[1] && !m_btn[2];
        red   = (m_ph == 0);
        leave = ce || (tk && m_sec == 1);

        if (leave) begin
            m_ph  = (m_ph + 1) % 3;
            m_sec = len_of[m_ph];
        end else if (tk) begin
            if (red && m_pend && m_sec > MR) m_sec = MR;
            else                             m_sec = m_sec - 1;
        end

        if (leave)          m_pend = 0;
        else if (pe && red) m_pend = 1;
        else if (tk && red) m_pend = 0;

        if (leave || tk) m_cnt = 0;
        else if (!p)     m_cnt = m_cnt + 1;

        m_cs_prev = c;
        m_btn[2] = m_btn[1]; m_btn[1] = m_btn[0]; m_btn[0] = r;

        e.ph = m_ph; e.sec = m_sec; e.pend = m_pend;
        e.tk = (m_cnt == TD - 1) && !p;
        q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    // Free-run until the model lands at (ph, sec) at the start of a second.
    task automatic run_until(input int ph, input int sec, input int maxc);
        int k = 0;
        while (!(m_ph == ph && m_sec == sec && m_cnt == 0) && k < maxc) begin
            step(0, 0, 0);
            k++;
        end
        if (k >= maxc) begin
            n_vec++; n_mis++;
            $display("FAIL run_until: got ph=%0d sec=%0d, want ph=%0d sec=%0d within %0d clk",
                     m_ph, m_sec, ph, sec, maxc);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("scoreboard", e);
            end
        end
    end

    // ---------------- driver ----------------
    initial begin
        exp_t rv;
        bit   rp, rc, rr;
        rv.ph = 0; rv.sec = RS; rv.pend = 0; rv.tk = 0;

        model_reset();
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", rv);

        // Reset release, full RED, then a free-running full cycle.
        run(24);
        run(52);

        // Pause mid-RED at second 4 for 20 clocks.
        run_until(0, 4, 200);
        for (int i = 0; i < 20; i++) step(1, 0, 0);
        run(8);

        // Manual strobe in GREEN at second 3, then again while paused.
        run_until(1, 3, 200);
        step(0, 1, 0);
        step(0, 0, 0);
        run(6);
        run_until(1, 3, 200);
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        run(4);

        // Pedestrian request at RED 5 (shortens), at RED 2 (no effect), in GREEN.
        run_until(0, 5, 200);
        step(0, 0, 1);
        run(8);
        run_until(0, 2, 200);
        step(0, 0, 1);
        run(8);
        run_until(1, 4, 200);
        step(0, 0, 1);
        run(8);

        // Strobe coincident with a tick while a request is pending in RED.
        run_until(0, 6, 200);
        step(0, 0, 1);
        for (int k = 0; !m_pend && k < 10; k++) step(0, 0, 0);
        for (int k = 0; m_cnt != TD - 1 && k < 10; k++) step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        run(4);

        // Randomised stretch.
        rp = 0; rc = 0; rr = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) rp = ~rp;
            if ($urandom_range(0, 11) == 0) rc = ~rc;
            if ($urandom_range(0, 9)  == 0) rr = ~rr;
            step(rp, rc, rr);
        end

        // Asynchronous reset mid-FLASH, between clock edges.
        run_until(2, 2, 200);
        run(1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", rv);
        model_reset();
        run(30);

        repeat (3) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_mis++;
            $display("FAIL queue_drain: got %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
